// File: rtl/regfile_pkg.sv
// Shared defaults and the index-width derivation for the multi-port register file.
package regfile_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NRD   = 2;

  // Index width for n registers, never narrower than one bit.
  function automatic int calc_aw(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit tracking: reserve sets, writes clear, flush clears all; per-port next-state lookup.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = 1,
  parameter int AW       = calc_aw(DEF_NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        wr_en,
  input  logic [2*AW-1:0]   wr_index,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_index,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rd_index,
  output logic [NRD-1:0]    rd_busy_nxt,
  output logic              any_busy
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Reserve is applied after the write clears so a same-cycle pair leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREGS; r++) begin
      for (int p = 0; p < 2; p++) begin
        if (wr_en[p] && wr_index[p*AW +: AW] == AW'(r)) busy_d[r] = 1'b0;
      end
      if (rsv_en && rsv_index == AW'(r) && !(ZERO_REG != 0 && r == 0)) busy_d[r] = 1'b1;
    end
    if (flush) busy_d = '0;
  end

  always_comb begin
    rd_busy_nxt = '0;
    for (int i = 0; i < NRD; i++) begin
      for (int r = 0; r < NREGS; r++) begin
        if (rd_index[i*AW +: AW] == AW'(r)) rd_busy_nxt[i] = busy_d[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= '0;
      any_busy <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      any_busy <= |busy_d;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Flop-based register file: two write ports (port 1 wins), NRD write-first read ports, busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = DEF_XLEN,
  parameter int NREGS    = DEF_NREGS,
  parameter int NRD      = DEF_NRD,
  parameter int ZERO_REG = 1,
  localparam int AW      = calc_aw(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          wr_en,
  input  logic [2*AW-1:0]     wr_index,
  input  logic [2*XLEN-1:0]   wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_index,
  input  logic                flush,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_index,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD-1:0]      rd_busy,
  output logic                any_busy
);

  logic [XLEN-1:0] regs   [NREGS];
  logic [XLEN-1:0] rd_val [NRD];
  logic [NRD-1:0]  rd_busy_nxt;

  function automatic logic writable(input int r);
    return !(ZERO_REG != 0 && r == 0);
  endfunction

  // Port 1 is visited last, so its assignment wins on an index collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        for (int p = 0; p < 2; p++) begin
          if (writable(r) && wr_en[p] && wr_index[p*AW +: AW] == AW'(r))
            regs[r] <= wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Write-first bypass; unmatched (out-of-range) and hardwired-zero indices read 0.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_val[i] = '0;
      for (int r = 0; r < NREGS; r++) begin
        if (writable(r) && rd_index[i*AW +: AW] == AW'(r)) begin
          rd_val[i] = regs[r];
          for (int p = 0; p < 2; p++) begin
            if (wr_en[p] && wr_index[p*AW +: AW] == AW'(r))
              rd_val[i] = wr_data[p*XLEN +: XLEN];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
      rd_addr <= '0;
      rd_busy <= '0;
    end else begin
      for (int i = 0; i < NRD; i++) begin
        if (rd_en[i]) begin
          rd_data[i*XLEN +: XLEN] <= rd_val[i];
          rd_addr[i*AW +: AW]     <= rd_index[i*AW +: AW];
          rd_busy[i]              <= rd_busy_nxt[i];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_index    (wr_index),
    .rsv_en      (rsv_en),
    .rsv_index   (rsv_index),
    .flush       (flush),
    .rd_index    (rd_index),
    .rd_busy_nxt (rd_busy_nxt),
    .any_busy    (any_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp with 24 registers, so indices 24..31 exercise the out-of-range rules.
module tb_regfile_mp;

  localparam int NREGS_T = 24;
  localparam int AW      = 5;

  logic        clk;
  logic        reset;
  logic [1:0]  wr_en;
  logic [9:0]  wr_index;
  logic [63:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_index;
  logic        flush;
  logic [1:0]  rd_en;
  logic [9:0]  rd_index;
  logic [63:0] rd_data;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_busy;
  logic        any_busy;

  regfile_mp #(
    .XLEN     (32),
    .NREGS    (NREGS_T),
    .NRD      (2),
    .ZERO_REG (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_index  (wr_index),
    .wr_data   (wr_data),
    .rsv_en    (rsv_en),
    .rsv_index (rsv_index),
    .flush     (flush),
    .rd_en     (rd_en),
    .rd_index  (rd_index),
    .rd_data   (rd_data),
    .rd_addr   (rd_addr),
    .rd_busy   (rd_busy),
    .any_busy  (any_busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents and busy set, plus held read outputs.
  logic [31:0] m_mem [32];
  logic [31:0] m_busy;
  logic [31:0] e_data [2];
  logic [4:0]  e_addr [2];
  logic        e_busy [2];
  logic        e_any;
  logic [31:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_checks++;
    if (got !== exp_v) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
    end
  endtask

  // Sequential semantics: writes in port order, then clears, reserve, flush; reads see the result.
  task automatic model_step();
    int wi;
    int ri;
    if (reset) begin
      for (int r = 0; r < 32; r++) m_mem[r] = '0;
      m_busy = '0;
      for (int i = 0; i < 2; i++) begin
        e_data[i] = '0;
        e_addr[i] = '0;
        e_busy[i] = 1'b0;
      end
      e_any = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        wi = int'(wr_index[p*AW +: AW]);
        if (wr_en[p] && wi < NREGS_T && wi != 0) m_mem[wi] = wr_data[p*32 +: 32];
        if (wr_en[p] && wi < NREGS_T) m_busy[wi] = 1'b0;
      end
      if (rsv_en && int'(rsv_index) < NREGS_T && rsv_index != 0) m_busy[rsv_index] = 1'b1;
      if (flush) m_busy = '0;
      for (int i = 0; i < 2; i++) begin
        if (rd_en[i]) begin
          ri = int'(rd_index[i*AW +: AW]);
          e_data[i] = (ri < NREGS_T && ri != 0) ? m_mem[ri] : 32'h0;
          e_addr[i] = rd_index[i*AW +: AW];
          e_busy[i] = (ri < NREGS_T) ? m_busy[ri] : 1'b0;
        end
      end
      e_any = |m_busy;
    end
  endtask

  // Driver: apply current inputs for one edge, then compare every output against the model.
  task automatic do_cycle();
    model_step();
    exp_q.push_back(e_data[0]);
    exp_q.push_back(e_data[1]);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rd_data%0d", i), 64'(rd_data[i*32 +: 32]), 64'(exp_q.pop_front()));
      check($sformatf("rd_addr%0d", i), 64'(rd_addr[i*AW +: AW]), 64'(e_addr[i]));
      check($sformatf("rd_busy%0d", i), 64'(rd_busy[i]), 64'(e_busy[i]));
    end
    check("any_busy", 64'(any_busy), 64'(e_any));
  endtask

  task automatic idle();
    reset     = 1'b0;
    wr_en     = '0;
    wr_index  = '0;
    wr_data   = '0;
    rsv_en    = 1'b0;
    rsv_index = '0;
    flush     = 1'b0;
    rd_en     = '0;
    rd_index  = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] idx, input logic [31:0] d);
    wr_en[p]             = 1'b1;
    wr_index[p*AW +: AW] = idx;
    wr_data[p*32 +: 32]  = d;
  endtask

  task automatic rd(input int i, input logic [4:0] idx);
    rd_en[i]             = 1'b1;
    rd_index[i*AW +: AW] = idx;
  endtask

  task automatic rsv(input logic [4:0] idx);
    rsv_en    = 1'b1;
    rsv_index = idx;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    do_cycle();
    do_cycle();
    check("rst_data", rd_data, 64'h0);
    check("rst_any", 64'(any_busy), 64'h0);

    // x5 write then read one cycle later
    idle(); wr(0, 5'd5, 32'hDEADBEEF); do_cycle();
    idle(); rd(0, 5'd5); do_cycle();
    check("x5_data", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("x5_addr", 64'(rd_addr[4:0]), 64'd5);

    // Both write ports hit x7, same-cycle read sees port 1
    idle(); wr(0, 5'd7, 32'h11); wr(1, 5'd7, 32'h22); rd(0, 5'd7); do_cycle();
    check("x7_bypass", 64'(rd_data[31:0]), 64'h22);
    idle(); rd(1, 5'd7); do_cycle();
    check("x7_later", 64'(rd_data[63:32]), 64'h22);
    idle(); do_cycle();
    check("hold_data", 64'(rd_data[31:0]), 64'h22);

    // Hardwired zero register
    idle(); wr(0, 5'd0, 32'hFFFFFFFF); rd(0, 5'd0); do_cycle();
    check("x0_same", 64'(rd_data[31:0]), 64'h0);
    idle(); rd(0, 5'd0); do_cycle();
    check("x0_next", 64'(rd_data[31:0]), 64'h0);
    idle(); rsv(5'd0); rd(0, 5'd0); do_cycle();
    check("x0_busy", 64'(rd_busy[0]), 64'h0);
    check("x0_any", 64'(any_busy), 64'h0);

    // Reserve/clear interplay on x3
    idle(); rsv(5'd3); do_cycle();
    idle(); rd(0, 5'd3); do_cycle();
    check("x3_busy", 64'(rd_busy[0]), 64'h1);
    check("x3_any", 64'(any_busy), 64'h1);
    idle(); wr(0, 5'd3, 32'h5); rsv(5'd3); rd(0, 5'd3); do_cycle();
    check("x3_rsv_wr", 64'(rd_busy[0]), 64'h1);
    idle(); wr(1, 5'd3, 32'h5); rd(0, 5'd3); do_cycle();
    check("x3_clr", 64'(rd_busy[0]), 64'h0);
    check("x3_clr_any", 64'(any_busy), 64'h0);
    check("x3_data", 64'(rd_data[31:0]), 64'h5);

    // Flush beats a same-cycle reserve
    idle(); rsv(5'd9); do_cycle();
    idle(); rsv(5'd10); do_cycle();
    check("rsv_any", 64'(any_busy), 64'h1);
    idle(); flush = 1'b1; rsv(5'd11); rd(1, 5'd11); do_cycle();
    check("flush_any", 64'(any_busy), 64'h0);
    check("flush_busy", 64'(rd_busy[1]), 64'h0);

    // Out-of-range indices
    idle(); wr(0, 5'd25, 32'hABC); rsv(5'd30); rd(0, 5'd25); do_cycle();
    check("oor_data", 64'(rd_data[31:0]), 64'h0);
    check("oor_any", 64'(any_busy), 64'h0);

    // Reset mid-stream discards write/reserve/read
    idle(); rsv(5'd2); wr(0, 5'd6, 32'h77); do_cycle();
    idle(); reset = 1'b1; wr(0, 5'd4, 32'h99); rd(0, 5'd4); do_cycle();
    check("rst_mid_data", rd_data, 64'h0);
    check("rst_mid_any", 64'(any_busy), 64'h0);
    idle(); rd(0, 5'd4); rd(1, 5'd6); do_cycle();
    check("x4_after_rst", 64'(rd_data[31:0]), 64'h0);
    check("x6_after_rst", 64'(rd_data[63:32]), 64'h0);

    // Randomized traffic, biased toward a small index set to provoke collisions
    for (int n = 0; n < 600; n++) begin
      idle();
      reset = ($urandom_range(0, 79) == 0);
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 1) == 1)
          wr(p, 5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31)), $urandom);
      end
      if ($urandom_range(0, 2) == 0) rsv(5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31)));
      flush = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) != 0)
          rd(i, 5'($urandom_range(0, 1) == 1 ? $urandom_range(0, 7) : $urandom_range(0, 31)));
      end
      do_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data width in bits.
REQ-002 Parameter NREGS, default 32, SHALL set the register count; AW = clog2(NREGS).
REQ-003 Parameter NRD, default 2, SHALL set the read-port count (1..4).
REQ-004 Parameter ZERO_REG, default 1, SHALL hardwire register 0 to zero when 1.
REQ-005 clk  in  1  the block's one clock; rising edge.
REQ-006 reset  in  1  reset, synchronous and active-high.
REQ-007 wr_en  in  2  per-write-port enable; port 1 has priority.
REQ-008 wr_index  in  2*AW  packed write indices.
REQ-009 wr_data  in  2*XLEN  packed write data.
REQ-010 rsv_en  in  1  reserve (mark busy) request.
REQ-011 rsv_index  in  AW  register being reserved.
REQ-012 flush  in  1  clear all busy bits.
REQ-013 rd_en  in  NRD  per-read-port enable.
REQ-014 rd_index  in  NRD*AW  packed read indices.
REQ-015 rd_data  out  NRD*XLEN  registered read data.
REQ-016 rd_addr  out  NRD*AW  registered echo of the captured rd_index.
REQ-017 rd_busy  out  NRD  registered busy flag for the captured index.
REQ-018 any_busy  out  1  OR of all busy bits (registered state).

Function
REQ-019 Writes SHALL commit on the clk edge; wr_en[1] SHALL win when both ports target one index.
REQ-020 With ZERO_REG=1, writes to index 0 SHALL be ignored, index 0 SHALL read 0, and index 0 SHALL never become busy.
REQ-021 Read latency SHALL be 1 cycle: when rd_en[i]=1, rd_data/rd_addr/rd_busy port i SHALL update on the next edge; when rd_en[i]=0 they SHALL hold.
REQ-022 Read SHALL be write-first: a same-cycle write to rd_index[i] SHALL be returned (port 1 data if both match), except index 0 under REQ-020.
REQ-023 Indices >= NREGS SHALL read 0, write nothing and never become busy.
REQ-024 Busy bit SHALL set on rsv_en and clear on any enabled write to that index.
REQ-025 Reserve and write to the same index in one cycle SHALL leave the bit set.
REQ-026 flush SHALL clear all busy bits and SHALL override a same-cycle rsv_en; writes SHALL still commit.
REQ-027 rd_busy[i] SHALL equal the next-state busy bit of rd_index[i] (after REQ-024..026).
REQ-028 any_busy SHALL reflect the busy vector registered at the current edge.

Reset
REQ-029 While reset=1 at an edge: all registers, busy bits, rd_data, rd_addr, rd_busy and any_busy SHALL become 0; writes, reserves and reads that cycle SHALL be discarded.
REQ-030 The first operation SHALL be accepted on the first edge with reset=0.

Structure
REQ-031 Package regfile_pkg SHALL hold default XLEN/NREGS/NRD constants and the AW derivation function.
REQ-032 Busy tracking SHALL be a sub-module regfile_scoreboard (NREGS busy bits, set/clear/flush, lookup per read port).
REQ-033 Storage SHALL be flops (no inferred RAM) so bypass and reset are exact.

Verification
REQ-034 Write x5=0xDEADBEEF on port 0; next cycle rd_en[0] index 5 -> one cycle later rd_data[0]=0xDEADBEEF, rd_addr[0]=5.
REQ-035 Same cycle wr port0 x7=0x11, port1 x7=0x22, read x7 -> rd_data=0x22; later read of x7 -> 0x22.
REQ-036 Write x0=0xFFFFFFFF, read x0 same and next cycle -> 0; rsv x0 -> rd_busy=0, any_busy=0.
REQ-037 rsv x3; read x3 next cycle -> rd_busy=1, any_busy=1; write x3=0x5 with rsv x3 same cycle -> busy stays 1; write x3 alone -> busy 0, any_busy 0.
REQ-038 rsv x9 and x10 over two cycles, then flush with rsv x11 -> all busy 0, any_busy 0 the next cycle.
REQ-039 Reset asserted mid-stream with wr_en=1 x4=0x99 -> rd_data 0, any_busy 0; after release read x4 -> 0.
